// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_ONES_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX = 4'd5;

    // A tens/ones pair is a legal 00..59 field.
    function automatic logic bcd_pair_ok(input logic [3:0] tens, input logic [3:0] ones);
        return (tens <= BCD_TENS_MAX) && (ones <= BCD_ONES_MAX);
    endfunction

endpackage

// File: rtl/bcd_down_00_59.sv
// Two-digit BCD down counter covering 59..00, with load and a borrow-out.
module bcd_down_00_59
    import bcd_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] ld_tens,
    input  logic [3:0] ld_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       borrow
);

    assign borrow = en && (tens == 4'd0) && (ones == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (load) begin
            tens <= ld_tens;
            ones <= ld_ones;
        end else if (en) begin
            if (ones == 4'd0) begin
                ones <= BCD_ONES_MAX;
                tens <= (tens == 4'd0) ? BCD_TENS_MAX : tens - 4'd1;
            end else begin
                ones <= ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_mmss.sv
// mm:ss BCD countdown timer with load/start/pause control and optional auto-reload.
//   state  | meaning
//   IDLE   | value loaded or reset, waiting for start
//   RUN    | counting down on tick
//   PAUSED | frozen, start resumes
//   DONE   | reached 00:00, held until a valid load
module bcd_countdown_mmss
    import bcd_timer_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_min_tens,
    input  logic [3:0] ld_min_ones,
    input  logic [3:0] ld_sec_tens,
    input  logic [3:0] ld_sec_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
);

    state_t      state, state_next;
    logic [15:0] preset;
    logic [15:0] cnt_ld;
    logic        ld_ok, load_ok, load_bad;
    logic        is_zero, is_one, preset_zero;
    logic        tick_act, expire, reload;
    logic        cnt_load, sec_en, sec_borrow, min_borrow;

    assign ld_ok       = bcd_pair_ok(ld_min_tens, ld_min_ones) && bcd_pair_ok(ld_sec_tens, ld_sec_ones);
    assign load_ok     = load && ld_ok;
    assign load_bad    = load && !ld_ok;
    assign is_zero     = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0000;
    assign is_one      = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0001;
    assign preset_zero = preset == 16'h0000;

    // Any load (even a rejected one) and any pause swallow a coincident tick.
    assign tick_act = (state == RUN) && tick && !load && !pause && !is_zero;
    assign expire   = tick_act && is_one;
    assign reload   = expire && AUTO_RELOAD && !preset_zero;
    assign cnt_load = load_ok || reload;
    assign cnt_ld   = load_ok ? {ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones} : preset;
    assign sec_en   = tick_act && !reload;

    bcd_down_00_59 u_sec (
        .clk     (clk),
        .rst     (rst),
        .en      (sec_en),
        .load    (cnt_load),
        .ld_tens (cnt_ld[7:4]),
        .ld_ones (cnt_ld[3:0]),
        .tens    (sec_tens),
        .ones    (sec_ones),
        .borrow  (sec_borrow)
    );

    bcd_down_00_59 u_min (
        .clk     (clk),
        .rst     (rst),
        .en      (sec_borrow),
        .load    (cnt_load),
        .ld_tens (cnt_ld[15:12]),
        .ld_ones (cnt_ld[11:8]),
        .tens    (min_tens),
        .ones    (min_ones),
        .borrow  (min_borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (load_ok) begin
            state_next = IDLE;
        end else if (!load) begin
            case (state)
                IDLE:    if (start && !is_zero) state_next = RUN;
                RUN: begin
                    if (pause)                   state_next = PAUSED;
                    else if (expire && !reload)  state_next = DONE;
                end
                PAUSED:  if (start) state_next = RUN;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            preset   <= 16'h0000;
            running  <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (load_ok) preset <= {ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones};
            running  <= state_next == RUN;
            done     <= state_next == DONE;
            expired  <= expire;
            load_err <= load_bad;
        end
    end

endmodule
